// File: rtl/and_or_issue.sv
// Issue stage for the and_or block: queues commands, drives one at a time onto the and_or
// inputs, and returns each sampled result over a valid/ready channel.
module and_or_issue #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CNT_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmdValid,
   output logic                  cmdReady,
   input  logic [DATA_WIDTH-1:0] cmdA,
   input  logic [DATA_WIDTH-1:0] cmdB,
   input  logic                  cmdOp,
   output logic [DATA_WIDTH-1:0] aIn,
   output logic [DATA_WIDTH-1:0] bIn,
   output logic                  doAnd,
   output logic                  doOr,
   input  logic [DATA_WIDTH-1:0] andOrOut,
   input  logic                  andOrIsAnd,
   output logic                  resValid,
   input  logic                  resReady,
   output logic [DATA_WIDTH-1:0] resData,
   output logic                  resIsAnd,
   output logic                  resErr,
   output logic [CNT_WIDTH-1:0]  cmdCount
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
   localparam int unsigned ENT_WIDTH = 2 * DATA_WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StResp} stateT;

   stateT                 stateQ, stateD;
   logic [ENT_WIDTH-1:0]  mem [DEPTH];
   logic [PTR_WIDTH-1:0]  wrPtr, rdPtr;
   logic [ENT_WIDTH-1:0]  head;
   logic                  push, pop, capture, goIdle;

   assign cmdReady = (cmdCount != CNT_WIDTH'(DEPTH));
   assign push     = cmdValid && cmdReady;
   assign head     = mem[rdPtr];

   // Storage needs no reset: occupancy is tracked by cmdCount and the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= {cmdOp, cmdA, cmdB};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         cmdCount <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_WIDTH'(1);
         end
         if (push && !pop) begin
            cmdCount <= cmdCount + CNT_WIDTH'(1);
         end else if (pop && !push) begin
            cmdCount <= cmdCount - CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD  = stateQ;
      pop     = 1'b0;
      capture = 1'b0;
      goIdle  = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (cmdCount != '0) begin
               pop    = 1'b1;
               stateD = StIssue;
            end
         end
         StIssue: begin
            capture = 1'b1;
            stateD  = StResp;
         end
         StResp: begin
            // resValid is always high here, so resReady alone completes the handshake
            if (resReady) begin
               if (cmdCount != '0) begin
                  pop    = 1'b1;
                  stateD = StIssue;
               end else begin
                  goIdle = 1'b1;
                  stateD = StIdle;
               end
            end
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aIn      <= '0;
         bIn      <= '0;
         doAnd    <= 1'b0;
         doOr     <= 1'b0;
         resValid <= 1'b0;
         resData  <= '0;
         resIsAnd <= 1'b0;
         resErr   <= 1'b0;
      end else begin
         if (pop) begin
            aIn      <= head[2*DATA_WIDTH-1:DATA_WIDTH];
            bIn      <= head[DATA_WIDTH-1:0];
            doAnd    <= head[ENT_WIDTH-1];
            doOr     <= ~head[ENT_WIDTH-1];
            resValid <= 1'b0;
         end
         if (capture) begin
            resData  <= andOrOut;
            resIsAnd <= andOrIsAnd;
            resErr   <= (andOrIsAnd != doAnd);
            resValid <= 1'b1;
         end
         if (goIdle) begin
            resValid <= 1'b0;
            doAnd    <= 1'b0;
            doOr     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_and_or_issue.sv
// Scoreboard bench for and_or_issue with an ideal and_or stub that can inject isAnd errors.
module tb_and_or_issue;

   localparam int DW = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmdValid = 1'b0, cmdReady, cmdOp = 1'b0;
   logic [DW-1:0] cmdA = '0, cmdB = '0;
   logic [DW-1:0] aIn, bIn, andOrOut, resData;
   logic          doAnd, doOr, andOrIsAnd, resValid, resIsAnd, resErr;
   logic          resReady = 1'b0;
   logic [CW-1:0] cmdCount;

   typedef struct {
      logic [DW-1:0] data;
      logic          isAnd;
      logic          err;
   } resT;

   resT expQ[$];
   resT monE;
   int  hsCyc[$];
   int  compared = 0;
   int  mismatched = 0;
   int  cyc = 0;
   bit  injectErr = 1'b0;
   bit  rndRun;

   and_or_issue #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdA(cmdA), .cmdB(cmdB), .cmdOp(cmdOp),
      .aIn(aIn), .bIn(bIn), .doAnd(doAnd), .doOr(doOr),
      .andOrOut(andOrOut), .andOrIsAnd(andOrIsAnd),
      .resValid(resValid), .resReady(resReady), .resData(resData),
      .resIsAnd(resIsAnd), .resErr(resErr), .cmdCount(cmdCount)
   );

   // Ideal and_or; operand A = 0110 under AND is the corrupted case when injection is on
   assign andOrOut   = doAnd ? (aIn & bIn) : (doOr ? (aIn | bIn) : '0);
   assign andOrIsAnd = doAnd && !(injectErr && aIn == 4'b0110);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic failNow(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic sendCmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
      int  n = 0;
      resT e;
      cmdValid = 1'b1;
      cmdA = a;
      cmdB = b;
      cmdOp = op;
      @(negedge clk);
      while (!cmdReady && n <= 300) begin
         n++;
         @(negedge clk);
      end
      if (n > 300) begin
         failNow("cmdAcceptTimeout");
      end else begin
         e.data  = op ? (a & b) : (a | b);
         e.err   = injectErr && op && (a == 4'b0110);
         e.isAnd = op && !e.err;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 300) begin
         n++;
         @(posedge clk);
      end
      if (expQ.size() != 0) failNow("drainTimeout");
      @(posedge clk);
      #1;
   endtask

   // Monitor: a result is consumed at the edge following a negedge with valid && ready
   always @(negedge clk) begin
      if (rst_n) begin
         check("oneHotDrive", {31'b0, doAnd && doOr}, 0);
         if (resValid && resReady) begin
            hsCyc.push_back(cyc);
            if (expQ.size() == 0) begin
               failNow("unexpectedResult");
            end else begin
               monE = expQ.pop_front();
               check("resData", resData, monE.data);
               check("resIsAnd", resIsAnd, monE.isAnd);
               check("resErr", resErr, monE.err);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] fa [6];
      logic [DW-1:0] fb [6];
      logic          fo [6];
      for (int i = 0; i < 6; i++) begin
         fa[i] = DW'(i * 3 + 1);
         fb[i] = DW'(15 - i);
         fo[i] = (i % 2 == 0);
      end

      repeat (2) @(posedge clk);
      #1;
      check("rstAIn", aIn, 0);
      check("rstBIn", bIn, 0);
      check("rstDoAnd", doAnd, 0);
      check("rstDoOr", doOr, 0);
      check("rstResValid", resValid, 0);
      check("rstResData", resData, 0);
      check("rstResIsAnd", resIsAnd, 0);
      check("rstResErr", resErr, 0);
      check("rstCount", cmdCount, 0);
      rst_n = 1'b1;
      #1;
      check("rstCmdReady", cmdReady, 1);
      @(posedge clk);
      #1;

      // Single AND
      resReady = 1'b1;
      sendCmd(4'b1100, 4'b1010, 1'b1);
      check("andCount", cmdCount, 1);
      check("andIdleDoAnd", doAnd, 0);
      @(posedge clk);
      #1;
      check("andAIn", aIn, 4'b1100);
      check("andBIn", bIn, 4'b1010);
      check("andDoAnd", doAnd, 1);
      check("andDoOr", doOr, 0);
      check("andNotYetValid", resValid, 0);
      @(posedge clk);
      #1;
      check("andValid", resValid, 1);
      check("andData", resData, 4'b1000);
      check("andIsAnd", resIsAnd, 1);
      check("andErr", resErr, 0);
      waitDrain();

      // Single OR, then back to idle
      sendCmd(4'b1100, 4'b0011, 1'b0);
      @(posedge clk);
      #1;
      check("orDoOr", doOr, 1);
      check("orDoAnd", doAnd, 0);
      @(posedge clk);
      #1;
      check("orValid", resValid, 1);
      check("orData", resData, 4'b1111);
      check("orIsAnd", resIsAnd, 0);
      @(posedge clk);
      #1;
      check("idleValid", resValid, 0);
      check("idleDoAnd", doAnd, 0);
      check("idleDoOr", doOr, 0);
      waitDrain();

      // Fill with backpressure, hold result for 10 cycles, then release
      resReady = 1'b0;
      hsCyc.delete();
      fork
         begin
            for (int i = 0; i < 6; i++) sendCmd(fa[i], fb[i], fo[i]);
         end
         begin
            repeat (8) @(posedge clk);
            #1;
            check("fullCount", cmdCount, 4);
            check("fullReady", cmdReady, 0);
            for (int k = 0; k < 10; k++) begin
               check("stallValid", resValid, 1);
               check("stallData", resData, fa[0] & fb[0]);
               check("stallAIn", aIn, fa[0]);
               check("stallBIn", bIn, fb[0]);
               check("stallDoAnd", doAnd, fo[0]);
               @(posedge clk);
               #1;
            end
            resReady = 1'b1;
         end
      join
      waitDrain();
      check("fillResults", hsCyc.size(), 6);
      for (int i = 1; i < hsCyc.size(); i++) check("resGap", hsCyc[i] - hsCyc[i-1], 2);

      // isAnd mismatch on one result only
      injectErr = 1'b1;
      sendCmd(4'b0110, 4'b0011, 1'b1);
      sendCmd(4'b0101, 4'b0111, 1'b1);
      waitDrain();
      injectErr = 1'b0;

      // Random commands under random backpressure
      rndRun = 1'b1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               sendCmd(DW'($urandom), DW'($urandom), 1'($urandom));
            end
            rndRun = 1'b0;
         end
         begin
            while (rndRun) begin
               @(posedge clk);
               #1;
               resReady = ($urandom_range(0, 3) != 0);
            end
         end
      join
      resReady = 1'b1;
      waitDrain();

      // Reset in ISSUE with three commands queued
      resReady = 1'b0;
      for (int i = 0; i < 5; i++) sendCmd(fa[i], fb[i], fo[i]);
      check("preRstCount", cmdCount, 4);
      resReady = 1'b1;
      @(posedge clk);
      #1;
      check("issueCount", cmdCount, 3);
      rst_n = 1'b0;
      #1;
      expQ.delete();
      check("midRstAIn", aIn, 0);
      check("midRstDoAnd", doAnd, 0);
      check("midRstDoOr", doOr, 0);
      check("midRstValid", resValid, 0);
      check("midRstData", resData, 0);
      check("midRstCount", cmdCount, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("noStaleResult", resValid, 0);
      sendCmd(4'b1001, 4'b0011, 1'b1);
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/and_or_issue.md
Name: and_or_issue

Overview:
- Upstream issue stage for the and_or combinational block.
- Buffers operation commands (A, B, op select) in a small FIFO and drives one command at a time onto the and_or inputs (aIn, bIn, doAnd, doOr).
- Samples the and_or result (out, isAnd) and returns it to the requester over a valid/ready result channel, flagging any isAnd/doAnd mismatch.

Parameters:
DATA_WIDTH, 4, width of operands and result
DEPTH, 4, command FIFO entries; power of two, >= 2
CNT_WIDTH, 3, width of cmdCount; must equal log2(DEPTH)+1

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmdValid  input  1  command present
cmdReady  output  1  FIFO can accept a command (= not full)
cmdA  input  DATA_WIDTH  operand A
cmdB  input  DATA_WIDTH  operand B
cmdOp  input  1  1 = AND, 0 = OR
aIn  output  DATA_WIDTH  to and_or.aIn, registered
bIn  output  DATA_WIDTH  to and_or.bIn, registered
doAnd  output  1  to and_or.doAnd, registered
doOr  output  1  to and_or.doOr, registered
andOrOut  input  DATA_WIDTH  from and_or.out
andOrIsAnd  input  1  from and_or.isAnd
resValid  output  1  result present
resReady  input  1  consumer accepts result
resData  output  DATA_WIDTH  captured andOrOut
resIsAnd  output  1  captured andOrIsAnd
resErr  output  1  captured andOrIsAnd differed from doAnd
cmdCount  output  CNT_WIDTH  FIFO occupancy, 0..DEPTH

Behaviour:

Reset (async, rst_n low):
- FIFO is emptied and cmdCount = 0.
- FSM goes to IDLE.
- aIn, bIn, doAnd, doOr, resValid, resData, resIsAnd and resErr all go to 0.
- cmdReady = 1 once rst_n is released.
- Reset mid-operation discards all queued and in-flight commands; no result is emitted for them.

Command FIFO:
- Push on cmdValid && cmdReady.
- cmdReady = (cmdCount != DEPTH), combinational from the registered count. There is no bypass when full.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves cmdCount unchanged.
- cmdValid while full is ignored; the requester must hold the command.

FSM, states IDLE / ISSUE / RESP:
- IDLE: doAnd = doOr = 0. If cmdCount != 0, pop the head, load aIn/bIn, set doAnd = op and doOr = ~op, then go to ISSUE. A command pushed at edge T is popped at edge T+1 (no same-edge bypass).
- ISSUE: lasts exactly one cycle while the drive registers are stable. At the end-of-cycle edge:
  - resData <= andOrOut
  - resIsAnd <= andOrIsAnd
  - resErr <= (andOrIsAnd != doAnd)
  - resValid <= 1, go to RESP.
- RESP: hold resData, resIsAnd, resErr, resValid and the drive registers stable. On resValid && resReady:
  - if FIFO is non-empty: pop the next command into the drive registers, clear resValid, go to ISSUE;
  - else: resValid <= 0, doAnd/doOr <= 0, go to IDLE.
- resReady is ignored outside RESP.

Timing and ordering:
- doAnd and doOr are never both 1.
- Latency: command accepted at edge T into an empty, idle block → resValid high after edge T+2.
- Throughput: one result per 2 cycles with resReady held high.
- Results are returned strictly in command order.
- Capacity with resReady low: 1 in-flight command plus DEPTH queued.

Test Plan:
- Single AND: reset, push A=4'b1100, B=4'b1010, op=1 at edge T, ideal and_or model → aIn/bIn/doAnd=1/doOr=0 after T+1; resValid after T+2 with resData=4'b1000, resIsAnd=1, resErr=0.
- Single OR: A=4'b1100, B=4'b0011, op=0 → doOr=1, doAnd=0; resData=4'b1111, resIsAnd=0, resErr=0; return to IDLE with doAnd=doOr=0.
- Fill/backpressure: resReady=0, cmdValid held with 6 distinct commands → 5 accepted, cmdCount reaches 4, cmdReady=0 and 6th held. Release resReady → 6th accepted once space frees; all 6 results in order, one every 2 cycles.
- Result stall: resReady=0 for 10 cycles in RESP → resData, resValid and drive registers remain constant.
- Mismatch: and_or stub forces isAnd=0 while doAnd=1 → resErr=1 for that result only; next correct result has resErr=0.
- Reset mid-operation: assert rst_n low in ISSUE with 3 queued → all outputs 0 asynchronously, cmdCount=0, no stale result after release; a new command completes normally.
